// File: rtl/threshold_sweep_controller.sv
// Sweeps the binarisation threshold over NUM_STEPS values, scores each one over a
// frame after discarding SETTLE_FRAMES frames, then locks onto the best-scoring threshold.
module threshold_sweep_controller #(
  parameter int NUM_STEPS       = 8,
  parameter int STEP_SIZE       = 32,
  parameter int START_THRESHOLD = 0,
  parameter int SETTLE_FRAMES   = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic        score_valid_in,
  input  logic [16:0] score_in,
  input  logic        recal_in,
  input  logic        manual_en_in,
  input  logic [7:0]  manual_threshold_in,
  output logic [7:0]  threshold_out,
  output logic        metric_clear_out,
  output logic        calibrating_out,
  output logic        locked_out,
  output logic [16:0] best_score_out,
  output logic [7:0]  step_out
);

  typedef enum logic [1:0] {SETTLE, MEASURE, LOCKED} state_t;

  localparam logic [7:0] LAST_STEP   = 8'(NUM_STEPS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES);
  localparam logic [7:0] START_THR   = 8'(START_THRESHOLD);

  // Wide arithmetic so large step products saturate instead of wrapping.
  function automatic logic [7:0] step_threshold(input logic [7:0] k);
    logic [31:0] t;
    t = 32'(START_THRESHOLD) + 32'(k) * 32'(STEP_SIZE);
    return (t > 32'd255) ? 8'd255 : t[7:0];
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  step_q, step_d;
  logic [3:0]  settle_q, settle_d;
  logic [16:0] best_score_q, best_score_d;
  logic [7:0]  best_thr_q, best_thr_d;
  logic [7:0]  threshold_q, threshold_d;
  logic        frame_q;
  logic        frame_edge;
  logic        clear;
  logic [7:0]  fsm_thr_d;

  // A held frame_start_in counts once, so metric_clear_out can never stretch.
  assign frame_edge = frame_start_in & ~frame_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    state_d      = state_q;
    step_d       = step_q;
    settle_d     = settle_q;
    best_score_d = best_score_q;
    best_thr_d   = best_thr_q;
    clear        = 1'b0;

    if (recal_in) begin
      state_d      = SETTLE;
      step_d       = 8'd0;
      settle_d     = 4'd0;
      best_score_d = 17'd0;
      best_thr_d   = START_THR;
    end else if (!manual_en_in) begin
      unique case (state_q)
        SETTLE: begin
          if (frame_edge) begin
            if (settle_q == SETTLE_LAST) begin
              clear    = 1'b1;
              settle_d = 4'd0;
              state_d  = MEASURE;
            end else begin
              settle_d = settle_q + 4'd1;
            end
          end
        end
        MEASURE: begin
          if (score_valid_in) begin
            if (score_in > best_score_q) begin
              best_score_d = score_in;
              best_thr_d   = step_threshold(step_q);
            end
            if (step_q == LAST_STEP) begin
              state_d = LOCKED;
            end else begin
              step_d = step_q + 8'd1;
              // A coincident frame start is already the first frame of the next step.
              if (frame_edge && SETTLE_LAST == 4'd0) begin
                clear    = 1'b1;
                settle_d = 4'd0;
                state_d  = MEASURE;
              end else begin
                settle_d = frame_edge ? 4'd1 : 4'd0;
                state_d  = SETTLE;
              end
            end
          end else if (frame_edge) begin
            clear = 1'b1;
          end
        end
        LOCKED:  ;
        default: state_d = SETTLE;
      endcase
    end

    fsm_thr_d = (state_d == LOCKED) ? best_thr_d : step_threshold(step_d);

    if (recal_in)          threshold_d = START_THR;
    else if (manual_en_in) threshold_d = manual_threshold_in;
    else                   threshold_d = fsm_thr_d;
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst_in) begin
      state_q      <= SETTLE;
      step_q       <= 8'd0;
      settle_q     <= 4'd0;
      best_score_q <= 17'd0;
      best_thr_q   <= START_THR;
      threshold_q  <= START_THR;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      settle_q     <= settle_d;
      best_score_q <= best_score_d;
      best_thr_q   <= best_thr_d;
      threshold_q  <= threshold_d;
      frame_q      <= frame_start_in;
    end
  end

  assign threshold_out    = threshold_q;
  assign metric_clear_out = clear & ~rst_in;
  assign calibrating_out  = (state_q != LOCKED);
  assign locked_out       = (state_q == LOCKED);
  assign best_score_out   = best_score_q;
  assign step_out         = step_q;

endmodule

// File: tb/tb_threshold_sweep_controller.sv
// Drives four differently-parameterised controllers with shared stimulus and compares
// them every cycle against a sweep model built from counters and plain arithmetic.
module tb_threshold_sweep_controller;

  localparam int NC = 4;
  localparam int P_NUM    [NC] = '{4, 4, 4, 8};
  localparam int P_STEP   [NC] = '{64, 32, 64, 32};
  localparam int P_START  [NC] = '{0, 200, 0, 0};
  localparam int P_SETTLE [NC] = '{1, 1, 0, 2};

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        score_valid_in = 1'b0;
  logic [16:0] score_in = '0;
  logic        recal_in = 1'b0;
  logic        manual_en_in = 1'b0;
  logic [7:0]  manual_threshold_in = '0;

  logic [7:0]  thr_w  [NC];
  logic        clr_w  [NC];
  logic        cal_w  [NC];
  logic        lock_w [NC];
  logic [16:0] best_w [NC];
  logic [7:0]  step_w [NC];

  always #5 clk_in = ~clk_in;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    threshold_sweep_controller #(
      .NUM_STEPS(P_NUM[g]), .STEP_SIZE(P_STEP[g]),
      .START_THRESHOLD(P_START[g]), .SETTLE_FRAMES(P_SETTLE[g])
    ) u_dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
      .score_valid_in(score_valid_in), .score_in(score_in), .recal_in(recal_in),
      .manual_en_in(manual_en_in), .manual_threshold_in(manual_threshold_in),
      .threshold_out(thr_w[g]), .metric_clear_out(clr_w[g]), .calibrating_out(cal_w[g]),
      .locked_out(lock_w[g]), .best_score_out(best_w[g]), .step_out(step_w[g])
    );
  end

  int checks = 0;
  int failures = 0;

  // Model: per-DUT sweep progress as counters and flags.
  int m_step [NC];
  int m_seen [NC];
  int m_best [NC];
  int m_bthr [NC];
  int m_thr  [NC];
  bit m_meas [NC];
  bit m_lock [NC];
  bit m_valid = 1'b0;
  bit prev_clr [NC];
  bit clr_seen [NC];

  bit man_lvl = 1'b0;
  int man_val = 0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0d expected=%0d at %0t", name, c, act, exp, $time);
    end
  endtask

  function automatic int thr_of(input int c, input int k);
    int t;
    t = P_START[c] + k * P_STEP[c];
    return (t > 255) ? 255 : t;
  endfunction

  function automatic bit exp_clear(input int c);
    if (rst_in || recal_in || manual_en_in || m_lock[c] || !frame_start_in) return 1'b0;
    if (!m_meas[c]) return (m_seen[c] == P_SETTLE[c]);
    if (!score_valid_in) return 1'b1;
    if (m_step[c] == P_NUM[c] - 1) return 1'b0;
    return (P_SETTLE[c] == 0);
  endfunction

  task automatic compare();
    for (int c = 0; c < NC; c++) begin
      clr_seen[c] = clr_w[c];
      if (m_valid) begin
        check("threshold_out", c, 32'(thr_w[c]), 32'(m_thr[c]));
        check("metric_clear_out", c, 32'(clr_w[c]), 32'(exp_clear(c)));
        check("calibrating_out", c, 32'(cal_w[c]), 32'(!m_lock[c]));
        check("locked_out", c, 32'(lock_w[c]), 32'(m_lock[c]));
        check("best_score_out", c, 32'(best_w[c]), 32'(m_best[c]));
        check("step_out", c, 32'(step_w[c]), 32'(m_step[c]));
        check("clear_back_to_back", c, 32'(clr_w[c] & prev_clr[c]), 32'd0);
      end
      prev_clr[c] = clr_w[c];
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NC; c++) begin
      if (rst_in || recal_in) begin
        m_step[c] = 0; m_seen[c] = 0; m_best[c] = 0; m_bthr[c] = P_START[c];
        m_meas[c] = 1'b0; m_lock[c] = 1'b0; m_thr[c] = P_START[c];
      end else if (manual_en_in) begin
        m_thr[c] = int'(manual_threshold_in);
      end else begin
        if (!m_lock[c]) begin
          if (m_meas[c]) begin
            if (score_valid_in) begin
              if (int'(score_in) > m_best[c]) begin
                m_best[c] = int'(score_in);
                m_bthr[c] = thr_of(c, m_step[c]);
              end
              if (m_step[c] == P_NUM[c] - 1) m_lock[c] = 1'b1;
              else begin
                m_step[c]++;
                m_meas[c] = 1'b0;
                m_seen[c] = 0;
                if (frame_start_in) begin
                  if (P_SETTLE[c] == 0) m_meas[c] = 1'b1;
                  else m_seen[c] = 1;
                end
              end
            end
          end else if (frame_start_in) begin
            if (m_seen[c] == P_SETTLE[c]) begin
              m_meas[c] = 1'b1;
              m_seen[c] = 0;
            end else m_seen[c]++;
          end
        end
        m_thr[c] = m_lock[c] ? m_bthr[c] : thr_of(c, m_step[c]);
      end
    end
    if (rst_in) m_valid = 1'b1;
  endtask

  // One clock: drive at the falling edge, compare 1 ns later, return after the next rising edge.
  task automatic cycle(input bit fs, input bit sv, input int score, input bit rc, input bit rs);
    frame_start_in      = fs;
    score_valid_in      = sv;
    score_in            = 17'(score);
    recal_in            = rc;
    rst_in              = rs;
    manual_en_in        = man_lvl;
    manual_threshold_in = 8'(man_val);
    #1;
    compare();
    model_update();
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic score(input int s);
    cycle(1'b0, 1'b1, s, 1'b0, 1'b0);
    idle(1);
  endtask

  int s1_score [4] = '{100, 300, 200, 300};
  int s1_thr0  [4] = '{0, 64, 128, 192};
  int s1_thr1  [4] = '{200, 232, 255, 255};
  int small_scores [4] = '{0, 100, 300, 76800};

  initial begin
    bit prev_fs;
    bit fs, sv, rc, rs;
    int sc;

    @(negedge clk_in);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(2);

    // Sweep of four thresholds; two frames discarded-then-cleared before each score.
    for (int k = 0; k < 4; k++) begin
      frame();
      frame();
      check("sweep_thr_cfg0", 0, 32'(thr_w[0]), 32'(s1_thr0[k]));
      check("sweep_thr_cfg1", 1, 32'(thr_w[1]), 32'(s1_thr1[k]));
      check("sweep_step", 0, 32'(step_w[0]), 32'(k));
      score(s1_score[k]);
    end
    check("lock_flag", 0, 32'(lock_w[0]), 32'd1);
    check("lock_thr", 0, 32'(thr_w[0]), 32'd64);
    check("lock_best", 0, 32'(best_w[0]), 32'd300);
    check("lock_thr_cfg1", 1, 32'(thr_w[1]), 32'd232);

    // Manual override while locked, with frames that must be ignored.
    man_lvl = 1'b1; man_val = 8'h55;
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("manual_thr", 0, 32'(thr_w[0]), 32'h55);
    cycle(1'b1, 1'b1, 9999, 1'b0, 1'b0);
    check("manual_no_clear", 0, 32'(clr_seen[0]), 32'd0);
    man_lvl = 1'b0;
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("manual_release_thr", 0, 32'(thr_w[0]), 32'd64);

    // Recalibrate from step 2 with best score 500.
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    frame(); frame(); score(500);
    frame(); frame(); score(100);
    check("pre_recal_step", 0, 32'(step_w[0]), 32'd2);
    check("pre_recal_best", 0, 32'(best_w[0]), 32'd500);
    cycle(1'b1, 1'b1, 600, 1'b1, 1'b0);
    check("recal_step", 0, 32'(step_w[0]), 32'd0);
    check("recal_thr", 0, 32'(thr_w[0]), 32'd0);
    check("recal_best", 0, 32'(best_w[0]), 32'd0);
    check("recal_cal", 0, 32'(cal_w[0]), 32'd1);
    check("recal_lock", 0, 32'(lock_w[0]), 32'd0);
    idle(1);

    // Dropped scores: two frame starts in MEASURE without a score.
    frame(); frame();
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("drop_clear_1", 0, 32'(clr_seen[0]), 32'd1);
    idle(1);
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("drop_clear_2", 0, 32'(clr_seen[0]), 32'd1);
    idle(1);
    check("drop_step", 0, 32'(step_w[0]), 32'd0);
    check("drop_thr", 0, 32'(thr_w[0]), 32'd0);
    score(77);
    frame(); frame();
    check("mid_measure_thr", 0, 32'(thr_w[0]), 32'd64);

    // Reset mid-MEASURE, with competing inputs in the same cycle.
    cycle(1'b1, 1'b1, 999, 1'b0, 1'b1);
    check("rst_clear", 0, 32'(clr_seen[0]), 32'd0);
    check("rst_thr", 0, 32'(thr_w[0]), 32'd0);
    check("rst_best", 0, 32'(best_w[0]), 32'd0);
    check("rst_step", 0, 32'(step_w[0]), 32'd0);
    check("rst_cal", 0, 32'(cal_w[0]), 32'd1);
    check("rst_lock", 0, 32'(lock_w[0]), 32'd0);
    check("rst_thr_cfg1", 1, 32'(thr_w[1]), 32'd200);
    idle(1);

    // Zero settle frames: coincident frame start and score.
    frame();
    cycle(1'b1, 1'b1, 50, 1'b0, 1'b0);
    check("coinc_clear", 2, 32'(clr_seen[2]), 32'd1);
    check("coinc_step", 2, 32'(step_w[2]), 32'd1);
    idle(1);
    score(60);
    check("coinc_measure", 2, 32'(step_w[2]), 32'd2);

    // Reset while manual override is active.
    man_lvl = 1'b1; man_val = 8'h33;
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("rst_in_manual_thr", 1, 32'(thr_w[1]), 32'd200);
    man_lvl = 1'b0;
    idle(1);

    // Randomised traffic against the model.
    prev_fs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      fs = !prev_fs && ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) == 0);
      sc = ($urandom_range(0, 2) == 0) ? small_scores[$urandom_range(0, 3)]
                                         : int'($urandom_range(0, 76800));
      rc = ($urandom_range(0, 99) == 0);
      rs = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0) man_lvl = ~man_lvl;
      man_val = int'($urandom_range(0, 255));
      cycle(fs, sv, sc, rc, rs);
      prev_fs = fs;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/threshold_sweep_controller.md
THRESHOLD_SWEEP_CONTROLLER -- requirements
Module: threshold_sweep_controller

Interface
REQ-001 The block SHALL have these parameters: NUM_STEPS, 8, thresholds tried per sweep (1..256); STEP_SIZE, 32, threshold increment per step; START_THRESHOLD, 0, first threshold of a sweep; SETTLE_FRAMES, 1, whole frames discarded after each threshold change (0..15).
REQ-002 The block SHALL have these ports:
- clk_in  in  1  sole clock.
- rst_in  in  1  synchronous, active-high reset.
- frame_start_in  in  1  one-cycle pulse at first pixel of each frame.
- score_valid_in  in  1  one-cycle pulse; score_in valid for the frame just finished.
- score_in  in  17  transition count of that frame (0..76800).
- recal_in  in  1  one-cycle pulse; restart the sweep.
- manual_en_in  in  1  level; manual threshold override.
- manual_threshold_in  in  8  override value.
- threshold_out  out  8  threshold to dither stage (registered).
- metric_clear_out  out  1  one-cycle pulse; metric block zeroes its count for the frame starting this cycle.
- calibrating_out  out  1  high in SETTLE or MEASURE.
- locked_out  out  1  high in LOCKED.
- best_score_out  out  17  highest score seen this sweep.
- step_out  out  8  current step index.

Function
REQ-003 The FSM SHALL have states SETTLE, MEASURE, LOCKED; the internal settle counter (4 bits) and step counter (8 bits) SHALL be registered.
REQ-004 The threshold for step k SHALL be START_THRESHOLD + k*STEP_SIZE, computed at least 17 bits wide and saturated to 255.
REQ-005 In SETTLE, on frame_start_in: if settle_cnt == SETTLE_FRAMES, then assert metric_clear_out that cycle, clear settle_cnt, go to MEASURE; else increment settle_cnt.
REQ-006 In MEASURE, on score_valid_in: if score_in > best_score (strict), then best_score <= score_in and best_threshold <= current threshold; a tie keeps the earlier, lower threshold.
REQ-007 In MEASURE, on score_valid_in with step < NUM_STEPS-1: step increments, threshold_out updates to the next step value on the following edge, and the FSM goes to SETTLE with settle_cnt 0.
REQ-008 In MEASURE, on score_valid_in with step == NUM_STEPS-1: go to LOCKED, and threshold_out <= the winning threshold, including the current step if it won this cycle.
REQ-009 In MEASURE, frame_start_in without score_valid_in SHALL be treated as a dropped score: metric_clear_out pulses again, and step, threshold and state are unchanged.
REQ-010 When frame_start_in and score_valid_in coincide in MEASURE, the score SHALL be processed per REQ-006..008.
REQ-011 In that coincident case, if the next state is SETTLE, the coincident pulse SHALL count as that step's first frame_start_in; with SETTLE_FRAMES=0 this means metric_clear_out pulses and the FSM returns directly to MEASURE.
REQ-012 In LOCKED, threshold_out SHALL equal best_threshold, and frame_start_in and score_valid_in SHALL be ignored.
REQ-013 score_valid_in outside MEASURE SHALL be ignored.
REQ-014 recal_in SHALL, from any state, set step 0, settle_cnt 0, best_score 0, best_threshold START_THRESHOLD, threshold_out START_THRESHOLD, and state SETTLE, on the next edge.
REQ-015 recal_in SHALL take priority over frame_start_in and score_valid_in in the same cycle.
REQ-016 While manual_en_in=1, threshold_out SHALL register manual_threshold_in (one-cycle latency), and the FSM SHALL freeze, ignoring frame_start_in and score_valid_in; recal_in is still honoured.
REQ-017 On deassertion of manual_en_in, threshold_out SHALL return to the FSM value on the next edge.
REQ-018 metric_clear_out SHALL never be high for more than one consecutive cycle.
REQ-019 metric_clear_out SHALL never assert in LOCKED or while manual_en_in=1.

Reset
REQ-020 On rst_in=1 at a clock edge: state SETTLE, step 0, settle_cnt 0, threshold_out START_THRESHOLD, best_score_out 0, best_threshold START_THRESHOLD, metric_clear_out 0, calibrating_out 1, locked_out 0, step_out 0.
REQ-021 rst_in SHALL override all other inputs, including mid-MEASURE and mid-manual.

Verification
REQ-022 Bench SHALL run these directed scenarios:
- NUM_STEPS=4, STEP_SIZE=64, SETTLE_FRAMES=1; scores 100,300,200,300 -> thresholds 0,64,128,192 in sequence; locked_out=1, threshold_out=64, best_score_out=300.
- START_THRESHOLD=200, STEP_SIZE=32, NUM_STEPS=4 -> threshold_out sequence 200,232,255,255.
- Two frame_start_in in MEASURE with no score -> metric_clear_out pulses twice; step_out and threshold_out unchanged.
- recal_in at step 2 with best_score 500 -> next cycle: step_out 0, threshold_out 0, best_score_out 0, calibrating_out 1, locked_out 0.
- SETTLE_FRAMES=0, frame_start_in coincident with score_valid_in -> metric_clear_out same cycle; state MEASURE with step+1.
- LOCKED at threshold 64, manual_en_in=1 with manual_threshold_in 0x55 -> threshold_out 0x55 after one cycle; deassert -> 64 after one cycle; rst_in mid-MEASURE -> all REQ-020 values.
